// File: rtl/mult_div_ctrl.sv
// -----------------------------------------------------------------------------
// mult_div_ctrl
//   Sequencer for MULT/DIV of the multicycle CPU. An iterative shift-add
//   multiplier and a restoring divider each run WIDTH steps on operand
//   magnitudes, then a FIX step applies two's-complement sign correction.
//   Results are written to HI/LO. div_zero feeds the exception logic.
//
// Optional feature macro: MULTDIV_UNSIGNED_EN
//   When defined, adds input unsigned_op (sampled with start). unsigned_op=1
//   skips magnitude/sign handling (MULTU/DIVU). When undefined, every
//   operation is signed and the port does not exist.
//
// Ports
//   clk         in   1      clock, rising edge
//   reset       in   1      synchronous reset, active-low
//   start_mult  in   1      start signed multiply (sampled in IDLE, wins over div)
//   start_div   in   1      start signed divide (sampled in IDLE)
//   unsigned_op in   1      (MULTDIV_UNSIGNED_EN only) treat operands as unsigned
//   op_a        in   WIDTH  rs operand, latched on the accepted start edge
//   op_b        in   WIDTH  rt operand, latched on the accepted start edge
//   busy        out  1      operation in flight (stays high through the done cycle)
//   done        out  1      one-cycle pulse: HI/LO valid, or div-by-zero abort
//   div_zero    out  1      one-cycle pulse with done when a DIV had op_b==0
//   hi          out  WIDTH  HI (mult: upper product, div: remainder)
//   lo          out  WIDTH  LO (mult: lower product, div: quotient)
//   dbg_state   out  3      current FSM state encoding
//
// Handshake: a start is accepted only on an edge where the FSM is IDLE; starts
// at any other time are dropped. done pulses for exactly one cycle with hi/lo
// already holding the result; busy falls on the cycle after done.
// -----------------------------------------------------------------------------
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_opnd;     // mult: |a| addend; div: |b| divisor
  logic [2*WIDTH-1:0] r_acc;      // mult: {partial hi, multiplier/lo}; div: {rem, quotient}
  logic               r_neg_res;  // product / quotient must be negated
  logic               r_neg_rem;  // remainder takes the dividend's sign
  logic               r_is_div;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_b_zero;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [2*WIDTH-1:0] w_fixed;

`ifdef MULTDIV_UNSIGNED_EN
  assign w_signed = ~unsigned_op;
`else
  assign w_signed = 1'b1;
`endif

  // A WIDTH-bit unsigned magnitude holds |-2^(WIDTH-1)| exactly, so the
  // most negative operand goes through the datapath without loss.
  assign w_a_neg  = w_signed & op_a[WIDTH-1];
  assign w_b_neg  = w_signed & op_b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? (~op_a + 1'b1) : op_a;
  assign w_mag_b  = w_b_neg ? (~op_b + 1'b1) : op_b;
  assign w_b_zero = (op_b == '0);

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder, keep
  // the difference only when it does not go negative.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_next  = w_div_ge ? {w_div_diff, r_acc[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod_neg = -r_acc;
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_quo_fix  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_fixed    = r_is_div ? {w_rem_fix, w_quo_fix}
                               : (r_neg_res ? w_prod_neg : r_acc);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_mult)     w_next_state = S_MULT;
        else if (start_div) w_next_state = w_b_zero ? S_DONE : S_DIV;
      end
      S_MULT:  if (r_cnt == '0) w_next_state = S_FIX;
      S_DIV:   if (r_cnt == '0) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_is_div   <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // done/div_zero are registered off the DONE state, so they (and the
      // hi/lo load) appear one edge after DONE is entered.
      r_done     <= (r_state == S_DONE);
      r_div_zero <= (r_state == S_DONE) & r_dz;
      case (r_state)
        S_IDLE: begin
          if (start_mult) begin
            r_opnd    <= w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= 1'b0;
            r_is_div  <= 1'b0;
            r_dz      <= 1'b0;
            r_cnt     <= CW'(WIDTH - 1);
          end else if (start_div) begin
            r_opnd    <= w_mag_b;
            r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_is_div  <= 1'b1;
            r_dz      <= w_b_zero;
            r_cnt     <= CW'(WIDTH - 1);
          end
        end
        S_MULT: begin
          r_acc <= w_mul_next;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: r_acc <= w_fixed;
        S_DONE: begin
          // A divide-by-zero abort leaves HI/LO untouched.
          if (!r_dz) begin
            r_hi <= r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_acc[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // busy covers the done-pulse cycle so the CPU never sees busy=0 before done.
  assign busy      = (r_state != S_IDLE) | r_done;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_ctrl.sv
`timescale 1ns/1ps
module tb_mult_div_ctrl;
  localparam int W  = 32;
  localparam int EW = 1 + 2*W + 32;   // {div_zero, hi, lo, due_cycle}

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_mult = 1'b0;
  logic         start_div = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
`ifdef MULTDIV_UNSIGNED_EN
  logic         unsigned_op = 1'b0;
`endif
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;
  logic [2:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;
  bit            expect_idle = 1'b0;

  mult_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .start_mult(start_mult), .start_div(start_div),
`ifdef MULTDIV_UNSIGNED_EN
    .unsigned_op(unsigned_op),
`endif
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain 64-bit signed arithmetic; SV '/' and '%' truncate toward zero with
  // the remainder following the dividend, which is the MIPS DIV definition.
  function automatic logic [EW-1:0] model(input bit is_div, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input int due0);
    longint sa, sb, p, q, r;
    logic [63:0] pv;
    logic [W-1:0] rh, rl;
    bit dz;
    int due;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    due = due0 + W + 2;
    if (!is_div) begin
      p = sa * sb; pv = p;
      rh = pv[63:32]; rl = pv[31:0];
    end else if (b == '0) begin
      dz = 1'b1; rh = m_hi; rl = m_lo; due = due0 + 1;
    end else begin
      q = sa / sb; r = sa % sb;
      pv = q; rl = pv[31:0];
      pv = r; rh = pv[31:0];
    end
    return {dz, rh, rl, due};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input bit sm, input bit sd, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [EW-1:0] e;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL idle_wait: busy stuck at %b, required 0", busy);
    end
    start_mult = sm; start_div = sd; op_a = a; op_b = b;
    e = model(sd && !sm, a, b, cyc + 1);
    exp_q.push_back(e);
    m_hi = e[95:64]; m_lo = e[63:32];
    @(negedge clk);
    start_mult = 1'b0; start_div = 1'b0;
    chk("busy_after_start", busy, 1);
    // operands must have been latched; scramble the live inputs
    op_a = $urandom; op_b = $urandom;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    start_mult = 1'b0; start_div = 1'b0;
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    repeat (n) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_div_zero", div_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (!rst_n) begin
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("busy_after_done", busy, 0);
        expect_idle = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: done=1 hi=0x%0h lo=0x%0h with nothing outstanding", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("hi", hi, e[95:64]);
          chk("lo", lo, e[63:32]);
          chk("div_zero", div_zero, e[96]);
          chk("done_cycle", cyc, e[31:0]);
          expect_idle = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    do_reset(3);

    issue(1, 0, 32'd7,         32'hFFFF_FFFD);   // 7 * -3
    issue(0, 1, 32'd5,         32'd0);           // div by zero, hi/lo hold
    issue(0, 1, 32'hFFFF_FFF9, 32'd2);           // -7 / 2
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);   // quotient wraps
    issue(1, 1, 32'h0001_0000, 32'h0001_0000);   // mult wins
    issue(1, 0, 32'h8000_0000, 32'h8000_0000);
    issue(0, 1, 32'd100,       32'hFFFF_FFF9);   // 100 / -7
    issue(0, 1, 32'd0,         32'd5);

    // starts arriving mid-operation are dropped
    issue(1, 0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(negedge clk);
    start_div = 1'b1; op_b = '0;
    @(negedge clk);
    start_div = 1'b0; start_mult = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start_mult = 1'b0;

    // abort by reset: mult in flight, stray div, then reset
    issue(1, 0, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    start_div = 1'b1; op_b = 32'd2;
    @(negedge clk);
    start_div = 1'b0;
    repeat (4) @(negedge clk);
    do_reset(1);
    repeat (50) @(negedge clk);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);

    for (int i = 0; i < 40; i++) begin
      bit sm, sd;
      sm = ($urandom_range(0, 1) == 1);
      sd = !sm || ($urandom_range(0, 4) == 0);
      issue(sm, sd, rand_op(), rand_op());
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
